regfile_wr_arbiter: RTL

//  Shares the single RegFile write port between two writeback requesters
//  (ch0 = ALU result, ch1 = load/memory result). Holds one pending write per

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_hold_buf.sv | 40 ++++
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared RegFile constants and the writeback request type used by the
// writeback stage, the write arbiter and RegFile.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a single writeback channel. A write to the
// zero register is accepted but never stored.
module wb_hold_buf
   import regfile_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    req_valid,
   input  wb_req_t req,
   input  logic    gnt,
   output logic    ready,
   output logic    loaded,
   output logic    v,
   output wb_req_t ent
);

   logic accept;

   // Refill is allowed in the same cycle the current entry is being written.
   assign ready  = reset & (~v | gnt);
   assign accept = req_valid & ready;
   assign loaded = accept & (req.addr != REG_ZERO);

   always_ff @(posedge clk) begin
      if (!reset) begin
         v <= 1'b0;
      end else if (loaded) begin
         v <= 1'b1;
      end else if (gnt) begin
         v <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (loaded) begin
         ent <= req;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single RegFile write port between the ALU (ch0) and load (ch1)
// writeback channels and publishes a pending-write mask for RAW stalls.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wb0_valid,
   output logic              wb0_ready,
   input  logic [ADDR_W-1:0] wb0_addr,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_valid,
   output logic              wb1_ready,
   input  logic [ADDR_W-1:0] wb1_addr,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              rg_wrt_en,
   output logic [ADDR_W-1:0] rg_wrt_addr,
   output logic [DATA_W-1:0] rg_wrt_data,
   output logic [NREG-1:0]   pend_mask
);

   wb_req_t req0, req1, ent0, ent1;
   logic    v0, v1, load0, load1, gnt0, gnt1;
   logic    rr_ptr, older, older_nxt, pick1;
   logic    nv0, nv1;

   assign req0 = '{addr: wb0_addr, data: wb0_data};
   assign req1 = '{addr: wb1_addr, data: wb1_data};

   wb_hold_buf u_buf0 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (wb0_valid),
      .req       (req0),
      .gnt       (gnt0),
      .ready     (wb0_ready),
      .loaded    (load0),
      .v         (v0),
      .ent       (ent0)
   );

   wb_hold_buf u_buf1 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (wb1_valid),
      .req       (req1),
      .gnt       (gnt1),
      .ready     (wb1_ready),
      .loaded    (load1),
      .v         (v1),
      .ent       (ent1)
   );

   // Same destination must commit in program order so the last write wins.
   always_comb begin
      pick1 = 1'b0;
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (reset) begin
         if (v0 & v1) begin
            pick1 = (ent0.addr == ent1.addr) ? older : rr_ptr;
            gnt0  = ~pick1;
            gnt1  = pick1;
         end else begin
            gnt0 = v0;
            gnt1 = v1;
         end
      end
   end

   // A refill in the grant cycle makes that entry the newer one.
   always_comb begin
      nv0       = load0 | (v0 & ~gnt0);
      nv1       = load1 | (v1 & ~gnt1);
      older_nxt = older;
      if (nv0 & nv1) begin
         if (load0 ^ load1) begin
            older_nxt = load0;
         end else if (load0) begin
            older_nxt = 1'b0;
         end
      end else begin
         older_nxt = nv1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr <= 1'b0;
         older  <= 1'b0;
      end else begin
         if (v0 & v1) begin
            rr_ptr <= ~pick1;
         end
         older <= older_nxt;
      end
   end

   always_comb begin
      rg_wrt_en   = gnt0 | gnt1;
      rg_wrt_addr = '0;
      rg_wrt_data = '0;
      if (gnt1) begin
         rg_wrt_addr = ent1.addr;
         rg_wrt_data = ent1.data;
      end else if (gnt0) begin
         rg_wrt_addr = ent0.addr;
         rg_wrt_data = ent0.data;
      end
   end

   always_comb begin
      pend_mask = '0;
      if (reset & v0) begin
         pend_mask[ent0.addr] = 1'b1;
      end
      if (reset & v1) begin
         pend_mask[ent1.addr] = 1'b1;
      end
   end

endmodule
